count_bcd_convert: RTL

- Downstream consumer of the 8-bit counter stage's count output.
- Converts each accepted binary count to packed BCD digits for display/monitor logic.
- Uses an iterative shift-add-3 (double-dabble) engine: one bit per clock, valid/ready input handshake, single-cycle done pulse.
- Shares the counter stage's clock, reset and enable nets.

---
 rtl/count_pkg.sv | 28 ++
 rtl/bcd_adj3.sv | 10 +
 rtl/count_bcd_convert.sv | 110 +++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared definitions for the counter stage and its BCD converter.
// Holds the converter state type, default widths and a digit-count helper.
package count_pkg;

  localparam int COUNT_WIDTH = 8;
  localparam int BCD_DIGITS  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Smallest digit count whose decimal range covers every width-bit value.
  function automatic int bcd_digits_needed(input int width);
    longint max_val;
    longint pow10;
    int     digits;
    max_val = (longint'(1) << width) - 1;
    pow10   = 1;
    digits  = 0;
    while (pow10 <= max_val) begin
      pow10  = pow10 * 10;
      digits = digits + 1;
    end
    return digits;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/count_bcd_convert.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per enabled
// clock, valid/ready input handshake and a single-cycle completion pulse.
module count_bcd_convert
  import count_pkg::*;
#(
  parameter int WIDTH  = COUNT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  out_valid,
  output logic                  busy
);

  // Handshake: a value is taken on a rising edge where in_valid and in_ready
  // are both high; in_ready is only offered in IDLE with enable high, and the
  // upstream keeps count_in/in_valid steady until that edge.

  localparam int BW = 4 * DIGITS;
  localparam int RW = BW + WIDTH;
  localparam int IW = $clog2(WIDTH + 1);

  if (DIGITS < bcd_digits_needed(WIDTH)) begin : g_digits_check
    $fatal(1, "count_bcd_convert: DIGITS too small for WIDTH");
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [RW-1:0]   r_work;
  logic [IW-1:0]   r_iter;
  logic [BW-1:0]   r_bcd;
  logic            r_out_valid;

  logic            w_accept;
  logic            w_step;
  logic            w_done;
  logic [BW-1:0]   w_adj_digits;
  logic [RW-1:0]   w_adj_work;
  logic [RW-1:0]   w_shifted;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .i_digit (r_work[WIDTH + 4*g +: 4]),
      .o_digit (w_adj_digits[4*g +: 4])
    );
  end

  assign w_adj_work = {w_adj_digits, r_work[WIDTH-1:0]};
  assign w_shifted  = w_adj_work << 1;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid && enable) begin
          w_accept    = 1'b1;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (enable) begin
          w_step = 1'b1;
          // The shift on this edge is the last one, so its result is final.
          if (r_iter == IW'(WIDTH - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_work      <= '0;
      r_iter      <= '0;
      r_bcd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= w_done;
      if (w_accept) begin
        r_work <= {{BW{1'b0}}, count_in};
        r_iter <= '0;
      end else if (w_step) begin
        r_work <= w_shifted;
        r_iter <= r_iter + IW'(1);
      end
      if (w_done) begin
        r_bcd <= w_shifted[RW-1 -: BW];
      end
    end
  end

  assign in_ready  = (r_state == IDLE) && enable;
  assign busy      = (r_state == SHIFT);
  assign bcd_out   = r_bcd;
  assign out_valid = r_out_valid;

endmodule
